// File: rtl/hid_kbd_pkg.sv
// Shared keycode constants, event record layout and scan state encoding for the
// HID keyboard event queue.
package hid_kbd_pkg;

  localparam logic [7:0] KEY_NONE         = 8'h00;
  localparam logic [7:0] KEY_ERR_ROLLOVER = 8'h01;

  localparam int EV_W = 18;

  // Event record, MSB first: repeat flag, make flag, modifier byte, keycode.
  typedef struct packed {
    logic       rpt;
    logic       make;
    logic [7:0] mods;
    logic [7:0] code;
  } key_event_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BREAK_SCAN,
    ST_MAKE_SCAN,
    ST_UPDATE
  } scan_state_t;

endpackage

// File: rtl/key_event_fifo.sv
// Power-of-two event FIFO with registered head; a push into a full FIFO is
// dropped (and flagged) unless the head is popped in the same cycle.
module key_event_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              ready,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              drop
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              empty, full, pop_ok, push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = ready && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;
  assign valid   = !empty;
  // Head is forced to zero while empty so stale storage never reaches the port.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/hid_key_event_queue.sv
// Diffs successive HID keyboard reports into make/break events queued for a consumer.
// Defining TYPEMATIC_EN adds a typematic repeat generator for the most recent make.
module hid_key_event_queue
  import hid_kbd_pkg::*;
#(
  parameter int NKEYS        = 6,
  parameter int DEPTH        = 8,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 2500000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               report_valid,
  input  logic [7:0]         modifiers,
  input  logic [8*NKEYS-1:0] keys,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [7:0]         ev_code,
  output logic [7:0]         ev_mods,
  output logic               ev_make,
  output logic               ev_repeat,
  output logic               busy,
  output logic               overflow,
  input  logic               ovf_clr
);
  localparam int IW = (NKEYS > 1) ? $clog2(NKEYS) : 1;
`ifdef TYPEMATIC_EN
  localparam int FIFO_W = EV_W;
`else
  localparam int FIFO_W = EV_W - 1;
`endif

  function automatic logic has_err(input logic [8*NKEYS-1:0] r);
    has_err = 1'b0;
    for (int j = 0; j < NKEYS; j++)
      if (r[8*j +: 8] == KEY_ERR_ROLLOVER) has_err = 1'b1;
  endfunction

  // True when code appears in any of the first lim slots of r.
  function automatic logic key_in(input logic [8*NKEYS-1:0] r, input logic [7:0] code,
                                  input int lim);
    key_in = 1'b0;
    for (int j = 0; j < NKEYS; j++)
      if (j < lim && r[8*j +: 8] == code) key_in = 1'b1;
  endfunction

  scan_state_t        state, state_nxt;
  logic [IW-1:0]      idx;
  logic               last_slot, report_ok, pend_valid;
  logic [8*NKEYS-1:0] old_keys, new_keys, pend_keys;
  logic [7:0]         old_mods, new_mods, pend_mods;
  int                 sidx;
  logic [7:0]         scan_code;
  logic               scan_make, scan_push;
  logic               fifo_push, fifo_drop;
  logic [FIFO_W-1:0]  fifo_din, fifo_dout;
  key_event_t         ev_head;

  assign last_slot = (idx == IW'(NKEYS-1));
  assign report_ok = report_valid && !has_err(keys);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (report_ok) state_nxt = ST_BREAK_SCAN;
      ST_BREAK_SCAN: if (last_slot) state_nxt = ST_MAKE_SCAN;
      ST_MAKE_SCAN:  if (last_slot) state_nxt = ST_UPDATE;
      ST_UPDATE:     state_nxt = (report_ok || pend_valid) ? ST_BREAK_SCAN : ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  // Duplicates within a report are suppressed by looking only at lower slots.
  always_comb begin
    busy      = (state != ST_IDLE);
    sidx      = int'(idx);
    scan_code = KEY_NONE;
    scan_make = 1'b0;
    scan_push = 1'b0;
    if (state == ST_BREAK_SCAN) begin
      scan_code = old_keys[8*sidx +: 8];
      scan_push = (scan_code != KEY_NONE) && !key_in(new_keys, scan_code, NKEYS) &&
                  !key_in(old_keys, scan_code, sidx);
    end else if (state == ST_MAKE_SCAN) begin
      scan_code = new_keys[8*sidx +: 8];
      scan_make = 1'b1;
      scan_push = (scan_code != KEY_NONE) && !key_in(old_keys, scan_code, NKEYS) &&
                  !key_in(new_keys, scan_code, sidx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      old_keys   <= '0;
      old_mods   <= '0;
      new_keys   <= '0;
      new_mods   <= '0;
      pend_keys  <= '0;
      pend_mods  <= '0;
      pend_valid <= 1'b0;
    end else begin
      if (state == ST_BREAK_SCAN || state == ST_MAKE_SCAN)
        idx <= last_slot ? '0 : idx + 1'b1;
      else
        idx <= '0;

      if (state == ST_IDLE) begin
        if (report_ok) begin
          new_keys <= keys;
          new_mods <= modifiers;
        end
      end else if (state == ST_UPDATE) begin
        // A report arriving in this very cycle is newer than anything pending.
        old_keys   <= new_keys;
        old_mods   <= new_mods;
        pend_valid <= 1'b0;
        if (report_ok) begin
          new_keys <= keys;
          new_mods <= modifiers;
        end else if (pend_valid) begin
          new_keys <= pend_keys;
          new_mods <= pend_mods;
        end
      end else if (report_ok) begin
        pend_keys  <= keys;
        pend_mods  <= modifiers;
        pend_valid <= 1'b1;
      end
    end
  end

`ifdef TYPEMATIC_EN
  logic [7:0]  rep_code;
  logic        rep_active, rep_first, rep_req, rep_fire;
  logic [31:0] rep_timer;

  // Scan events take the FIFO port first; a due repeat simply waits while rep_req holds.
  always_comb begin
    rep_req   = rep_active &&
                (rep_timer >= (rep_first ? 32'(REPEAT_DELAY) : 32'(REPEAT_RATE)));
    rep_fire  = rep_req && !scan_push;
    fifo_push = scan_push || rep_req;
    fifo_din  = scan_push ? {1'b0, scan_make, new_mods, scan_code}
                          : {1'b1, 1'b1, old_mods, rep_code};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_code   <= KEY_NONE;
      rep_active <= 1'b0;
      rep_first  <= 1'b0;
      rep_timer  <= '0;
    end else if (scan_push && scan_make) begin
      rep_code   <= scan_code;
      rep_active <= 1'b1;
      rep_first  <= 1'b1;
      rep_timer  <= 32'd1;
    end else if (scan_push && scan_code == rep_code) begin
      rep_active <= 1'b0;
      rep_timer  <= '0;
    end else if (rep_fire) begin
      rep_first  <= 1'b0;
      rep_timer  <= 32'd1;
    end else if (rep_active && !rep_req) begin
      rep_timer  <= rep_timer + 32'd1;
    end
  end
`else
  assign fifo_push = scan_push;
  assign fifo_din  = {scan_make, new_mods, scan_code};
`endif

  key_event_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (fifo_din),
    .ready (ev_ready),
    .dout  (fifo_dout),
    .valid (ev_valid),
    .drop  (fifo_drop)
  );

  // Without the repeat generator the stored record lacks the repeat bit, so it reads 0.
  assign ev_head   = key_event_t'(EV_W'(fifo_dout));
  assign ev_code   = ev_head.code;
  assign ev_mods   = ev_head.mods;
  assign ev_make   = ev_head.make;
  assign ev_repeat = ev_head.rpt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         overflow <= 1'b0;
    else if (fifo_drop) overflow <= 1'b1;
    else if (ovf_clr)   overflow <= 1'b0;
  end

endmodule

// File: doc/hid_key_event_queue.md
HID_KEY_EVENT_QUEUE -- requirements
Module: hid_key_event_queue

Interface
REQ-001 SHALL have parameter NKEYS, default 6, number of keycode slots per HID report.
REQ-002 SHALL have parameter DEPTH, default 8, event FIFO entries, power of two.
REQ-003 SHALL have parameter REPEAT_DELAY, default 25000000, clk cycles before the first typematic repeat.
REQ-004 SHALL have parameter REPEAT_RATE, default 2500000, clk cycles between repeats.
REQ-005 SHALL have port clk, input, 1, sole clock.
REQ-006 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-007 SHALL have port report_valid, input, 1, one-cycle strobe qualifying a new report.
REQ-008 SHALL have port modifiers, input, 8, HID modifier byte.
REQ-009 SHALL have port keys, input, 8*NKEYS, keycode slots, slot 0 in the LSBs.
REQ-010 SHALL have port ev_valid, output, 1, FIFO head valid.
REQ-011 SHALL have port ev_ready, input, 1, consumer pops the head when ev_valid and ev_ready are both high.
REQ-012 SHALL have port ev_code, output, 8, keycode of the head event.
REQ-013 SHALL have port ev_mods, output, 8, modifiers latched with the report that generated the event.
REQ-014 SHALL have port ev_make, output, 1, 1 for press, 0 for release.
REQ-015 SHALL have port ev_repeat, output, 1, event is a typematic repeat.
REQ-016 SHALL have port busy, output, 1, scan in progress.
REQ-017 SHALL have port overflow, output, 1, sticky event-loss flag.
REQ-018 SHALL have port ovf_clr, input, 1, clears overflow.

Function
REQ-019 SHALL run FSM IDLE -> BREAK_SCAN -> MAKE_SCAN -> UPDATE -> IDLE, or -> BREAK_SCAN again if a report is pending.
REQ-020 SHALL latch modifiers and keys on report_valid in IDLE, then enter BREAK_SCAN the next cycle.
REQ-021 BREAK_SCAN SHALL visit one old-report slot per cycle, NKEYS cycles, and push a break for each nonzero old code absent from the new report.
REQ-022 MAKE_SCAN SHALL visit one new-report slot per cycle, NKEYS cycles, and push a make for each nonzero new code absent from the old report.
REQ-023 UPDATE SHALL copy the new report into the old report in one cycle.
REQ-024 busy SHALL be high from the cycle after acceptance through UPDATE, 2*NKEYS+1 cycles.
REQ-025 A pushed event SHALL be visible on ev_valid the cycle after the push.
REQ-026 Slots holding 0x00 SHALL be ignored.
REQ-027 A report containing 0x01 (rollover error) in any slot SHALL be discarded entirely, with no events and old report kept.
REQ-028 A duplicate code within one report SHALL produce one event only, at the lowest slot.
REQ-029 report_valid while busy SHALL be stored in a one-deep pending register, latest report wins.
REQ-030 A push to a full FIFO SHALL drop the event and set overflow, unless a pop occurs in the same cycle, in which case the push is accepted.
REQ-031 Simultaneous push and pop when the FIFO is empty SHALL be legal and SHALL leave the FIFO holding the new event.
REQ-032 FIFO pointers SHALL wrap modulo DEPTH, with a log2(DEPTH)+1-bit count distinguishing full from empty.
REQ-033 ovf_clr SHALL clear overflow; a simultaneous new drop SHALL win and keep overflow set.

Reset
REQ-034 rst_n low SHALL asynchronously force: FSM to IDLE, old and pending reports to 0, FIFO empty, ev_valid=0, ev_code=0, ev_mods=0, ev_make=0, ev_repeat=0, busy=0, overflow=0, repeat timer to 0.
REQ-035 Reset mid-scan SHALL abort the scan with no partial events retained.

Configuration
REQ-036 With TYPEMATIC_EN defined, the last make's code SHALL be tracked, and after REPEAT_DELAY cycles held, then every REPEAT_RATE cycles, a make event with ev_repeat=1 and current modifiers SHALL be pushed.
REQ-037 Typematic tracking SHALL cancel on that key's break or on a newer make, and restart its delay on a newer make.
REQ-038 A scan push SHALL have priority over a repeat push; the repeat push SHALL be deferred one cycle.
REQ-039 Without TYPEMATIC_EN, no repeat logic SHALL exist and ev_repeat SHALL be constant 0.

Structure
REQ-040 Package hid_kbd_pkg SHALL hold KEY_NONE=8'h00, KEY_ERR_ROLLOVER=8'h01, and the 18-bit event field layout.
REQ-041 The FIFO SHALL be sub-module key_event_fifo, parametrised by DEPTH and width.

Verification
REQ-042 Test press: keys={0x04} -> one event {code 0x04, make=1, repeat=0}, ev_valid high 2*NKEYS-... no later than T+2*NKEYS+2.
REQ-043 Test rollover: old {0x04}, new {0x05}, then {0x01,0x01..} -> break 0x04, make 0x05; the error report produces no events.
REQ-044 Test overflow: DEPTH=8, ev_ready=0, 9 distinct makes -> 8 events queued, overflow=1; ovf_clr -> overflow=0.
REQ-045 Test back-to-back: two reports 1 cycle apart while busy -> both processed in order, third mid-scan replaces pending.
REQ-046 Test typematic (TYPEMATIC_EN, REPEAT_DELAY=100, REPEAT_RATE=20): hold 0x1E -> repeats at +100, +120, +140; release -> none further.
REQ-047 Test reset: assert rst_n low mid-MAKE_SCAN -> all outputs 0 asynchronously, FIFO empty.
